ber_meas_ctrl: RTL
==================

Name: ber_meas_ctrl

Overview:
Sequencer for receiver bit-error-rate measurement on the demodulated err/val stream. It arms on command and waits for pattern lock (a run of error-free bits). It then counts errors over a fixed window of valid bits and publishes a latched result with a one-cycle strobe. It also handles loss of lock and a stalled val stream, and sits between the Rx bit checker and the host/status register interface.

Parameters:
WINDOW, 1_000_000, valid bits per measurement window
CW, 24, counter/result width; must satisfy WINDOW < 2**CW
LOCK_LEN, 64, consecutive error-free valid bits needed to declare lock
LOS_BLK, 256, valid-bit block length used for loss-of-lock check during measurement
LOS_THR, 32, errors within one LOS_BLK block that declare loss of lock
TIMEOUT, 1_000_000, clk cycles without val before stall is declared

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; arm a measurement
cont  in  1  1 = restart automatically after each result; sampled in DONE
abort  in  1  return to IDLE and discard the window in progress
err  in  1  bit error flag, qualified by val
val  in  1  bit valid
busy  out  1  high in any state except IDLE
locked  out  1  high in MEAS
n_er  out  CW  errors in the last completed window
n_bits  out  CW  bits in the last window (WINDOW, or partial on stall)
res_val  out  1  one-cycle strobe when n_er/n_bits update
stall  out  1  sticky; last result ended by timeout; cleared on start
los  out  1  sticky; lock lost at least once since start; cleared on start

Behaviour:
- Reset (asynchronous): state=IDLE; all counters 0; n_er=0, n_bits=0, res_val=0, stall=0, los=0.
- States: IDLE, SYNC, MEAS, DONE.
- IDLE: on start go to SYNC, clear stall and los. start in any other state is ignored.
- SYNC: run counter increments on val&!err and clears on val&err.
  - When the run counter reaches LOCK_LEN-1 and another val&!err arrives, go to MEAS next cycle.
  - Bits seen in SYNC are never counted.
- MEAS:
  - bit_cnt increments on val; err_cnt increments on val&err.
  - The bit on which bit_cnt reaches WINDOW-1 is included. Next cycle: n_er=err_cnt (final), n_bits=WINDOW, state=DONE.
  - Result registers update in the same cycle that state becomes DONE; res_val is high that cycle only.
- Loss of lock (MEAS only):
  - blk_cnt counts val mod LOS_BLK; blk_err counts errors within the current block.
  - If blk_err reaches LOS_THR, set los, discard the window (counters cleared, no res_val) and return to SYNC.
  - blk_cnt and blk_err clear at each block boundary.
- Stall: idle counter counts clk cycles with val=0 in SYNC or MEAS and clears on any val.
  - At TIMEOUT in MEAS: n_bits=bit_cnt, n_er=err_cnt+(WINDOW-bit_cnt) (missing bits counted as errors), set stall, pulse res_val, go to DONE.
  - At TIMEOUT in SYNC: n_bits=0, n_er=WINDOW, set stall, pulse res_val, go to DONE.
- DONE (one cycle): if cont=1 go to SYNC, keeping n_er and n_bits; otherwise go to IDLE.
- abort has priority over every other event in all states. Go to IDLE next cycle, clear working counters, no res_val; n_er and n_bits hold.
- Same-cycle precedence: abort > window complete > loss of lock > timeout. If the final window bit also crosses LOS_THR, the result is published and los is still set.
- No counter wraps; n_er never exceeds WINDOW.

Decomposition:
- Package ber_pkg: state enum (IDLE, SYNC, MEAS, DONE) and the default constants WINDOW, LOCK_LEN, LOS_BLK, LOS_THR, TIMEOUT, CW.
- One natural sub-module, ber_win_cnt: bit/error counters plus the LOS block counters, with clear and enable inputs from the FSM.
- The FSM, stall timer and result registers stay in the top level.

Test Plan (WINDOW=100, LOCK_LEN=8, LOS_BLK=16, LOS_THR=4, TIMEOUT=50):
- start, val every cycle, err=0 -> locked after 8 valid bits; res_val after 100 more valid bits; n_er=0, n_bits=100; return to IDLE with cont=0.
- As above, err on MEAS bits 10, 50 and the last bit (index 99) -> n_er=3; with cont=1 a second result 108 valid bits later.
- In SYNC, err on bit 5 -> lock delayed; locked rises on the 8th error-free bit after the error.
- In MEAS, 4 errors within one 16-bit block -> los=1, locked drops, no res_val; relock, then a clean window gives n_er=0 with los still 1.
- val stops after 30 MEAS bits with 2 errors -> 50 cycles later res_val=1, n_bits=30, n_er=72, stall=1; next start clears stall.
- abort mid-MEAS and rst asserted mid-MEAS (between clock edges) -> IDLE, no res_val. After rst all outputs are 0 without a clock edge. After abort the previous n_er is held.

Source files
------------

// File: rtl/ber_meas_ctrl_pkg.sv
// Shared types and default constants for the BER measurement sequencer.
//   state_t     : sequencer states
//   DEF_*       : default parameter values for ber_meas_ctrl and ber_win_cnt
package ber_pkg;

   localparam int unsigned DEF_WINDOW   = 1_000_000;
   localparam int unsigned DEF_CW       = 24;
   localparam int unsigned DEF_LOCK_LEN = 64;
   localparam int unsigned DEF_LOS_BLK  = 256;
   localparam int unsigned DEF_LOS_THR  = 32;
   localparam int unsigned DEF_TIMEOUT  = 1_000_000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      MEAS = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/ber_meas_ctrl_if.sv
// Host / bit-checker side bundle of ber_meas_ctrl.
//   start, cont, abort : host commands
//   err, val           : demodulated bit-error stream
//   busy, locked       : live status
//   n_er, n_bits       : latched result, res_val strobes on update
//   stall, los         : sticky flags, cleared on start
interface ber_meas_ctrl_if #(
   parameter int unsigned CW = ber_pkg::DEF_CW
);
   logic          start;
   logic          cont;
   logic          abort;
   logic          err;
   logic          val;
   logic          busy;
   logic          locked;
   logic [CW-1:0] n_er;
   logic [CW-1:0] n_bits;
   logic          res_val;
   logic          stall;
   logic          los;

   modport master (
      output start, cont, abort, err, val,
      input  busy, locked, n_er, n_bits, res_val, stall, los
   );

   modport slave (
      input  start, cont, abort, err, val,
      output busy, locked, n_er, n_bits, res_val, stall, los
   );
endinterface

// File: rtl/ber_win_cnt.sv
// Window bit/error counters plus loss-of-lock block counters.
//   i_clr        : zero all counters (priority over counting)
//   i_en         : counting enabled (sequencer in MEAS)
//   i_val, i_err : bit stream
//   o_bit_cnt    : valid bits counted so far in the window
//   o_err_cnt    : errors counted so far in the window
//   o_err_tot_c  : error count including the current bit
//   o_win_last_c : current bit is the last bit of the window
//   o_los_hit_c  : current bit brings the block error count to LOS_THR
module ber_win_cnt #(
   parameter int unsigned WINDOW  = ber_pkg::DEF_WINDOW,
   parameter int unsigned CW      = ber_pkg::DEF_CW,
   parameter int unsigned LOS_BLK = ber_pkg::DEF_LOS_BLK,
   parameter int unsigned LOS_THR = ber_pkg::DEF_LOS_THR
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_en,
   input  logic          i_val,
   input  logic          i_err,
   output logic [CW-1:0] o_bit_cnt,
   output logic [CW-1:0] o_err_cnt,
   output logic [CW-1:0] o_err_tot_c,
   output logic          o_win_last_c,
   output logic          o_los_hit_c
);
   localparam int unsigned BW = (LOS_BLK > 1) ? $clog2(LOS_BLK) : 1;
   localparam int unsigned EW = (LOS_THR > 1) ? $clog2(LOS_THR) : 1;

   logic [CW-1:0] r_bit_cnt;
   logic [CW-1:0] r_err_cnt;
   logic [BW-1:0] r_blk_cnt;
   logic [EW-1:0] r_blk_err;
   logic          w_step;
   logic          w_blk_end;

   assign w_step       = i_en & i_val;
   assign w_blk_end    = (r_blk_cnt == BW'(LOS_BLK - 1));
   assign o_win_last_c = w_step & (r_bit_cnt == CW'(WINDOW - 1));
   // Block error counter saturates by construction: the hit forces a clear.
   assign o_los_hit_c  = w_step & i_err & (r_blk_err == EW'(LOS_THR - 1));
   assign o_err_tot_c  = r_err_cnt + CW'(i_err);
   assign o_bit_cnt    = r_bit_cnt;
   assign o_err_cnt    = r_err_cnt;

   // Window and block counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt <= '0;
         r_err_cnt <= '0;
         r_blk_cnt <= '0;
         r_blk_err <= '0;
      end else if (i_clr) begin
         r_bit_cnt <= '0;
         r_err_cnt <= '0;
         r_blk_cnt <= '0;
         r_blk_err <= '0;
      end else if (w_step) begin
         r_bit_cnt <= r_bit_cnt + CW'(1);
         r_err_cnt <= o_err_tot_c;
         if (w_blk_end) begin
            r_blk_cnt <= '0;
            r_blk_err <= '0;
         end else begin
            r_blk_cnt <= r_blk_cnt + BW'(1);
            r_blk_err <= r_blk_err + EW'(i_err);
         end
      end
   end
endmodule

// File: rtl/ber_meas_ctrl.sv
// BER measurement sequencer: arm, lock on an error-free run, count errors
// over a fixed window, publish a latched result; handles loss of lock,
// stalled val stream and abort.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : command / bit stream / result bundle (slave side)
module ber_meas_ctrl
   import ber_pkg::*;
#(
   parameter int unsigned WINDOW   = DEF_WINDOW,
   parameter int unsigned CW       = DEF_CW,
   parameter int unsigned LOCK_LEN = DEF_LOCK_LEN,
   parameter int unsigned LOS_BLK  = DEF_LOS_BLK,
   parameter int unsigned LOS_THR  = DEF_LOS_THR,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   ber_meas_ctrl_if.slave   bus
);
   localparam int unsigned RW = (LOCK_LEN > 1) ? $clog2(LOCK_LEN) : 1;
   localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        r_state, w_state_nxt;
   logic [RW-1:0] r_run;
   logic [IW-1:0] r_idle;
   logic [CW-1:0] r_n_er, r_n_bits, w_n_er_nxt, w_n_bits_nxt;
   logic          r_res_val, r_stall, r_los, r_busy, r_locked;
   logic          w_pub, w_set_stall, w_set_los, w_clr_flags, w_timeout;
   logic [CW-1:0] w_bit_cnt, w_err_cnt, w_err_tot;
   logic          w_win_last, w_los_hit;

   ber_win_cnt #(
      .WINDOW  (WINDOW),
      .CW      (CW),
      .LOS_BLK (LOS_BLK),
      .LOS_THR (LOS_THR)
   ) u_win_cnt (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (w_state_nxt != MEAS),
      .i_en         (r_state == MEAS),
      .i_val        (bus.val),
      .i_err        (bus.err),
      .o_bit_cnt    (w_bit_cnt),
      .o_err_cnt    (w_err_cnt),
      .o_err_tot_c  (w_err_tot),
      .o_win_last_c (w_win_last),
      .o_los_hit_c  (w_los_hit)
   );

   assign w_timeout = ~bus.val & (r_idle == IW'(TIMEOUT - 1));

   // Next state, result selection; abort > window > loss of lock > timeout
   always_comb begin
      w_state_nxt  = r_state;
      w_pub        = 1'b0;
      w_n_er_nxt   = r_n_er;
      w_n_bits_nxt = r_n_bits;
      w_set_stall  = 1'b0;
      w_set_los    = 1'b0;
      w_clr_flags  = 1'b0;
      if (bus.abort) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  w_state_nxt = SYNC;
                  w_clr_flags = 1'b1;
               end
            end
            SYNC: begin
               if (bus.val && !bus.err && (r_run == RW'(LOCK_LEN - 1))) begin
                  w_state_nxt = MEAS;
               end else if (w_timeout) begin
                  w_state_nxt  = DONE;
                  w_pub        = 1'b1;
                  w_set_stall  = 1'b1;
                  w_n_bits_nxt = '0;
                  w_n_er_nxt   = CW'(WINDOW);
               end
            end
            MEAS: begin
               if (w_win_last) begin
                  w_state_nxt  = DONE;
                  w_pub        = 1'b1;
                  w_set_los    = w_los_hit;
                  w_n_bits_nxt = CW'(WINDOW);
                  w_n_er_nxt   = w_err_tot;
               end else if (w_los_hit) begin
                  w_state_nxt = SYNC;
                  w_set_los   = 1'b1;
               end else if (w_timeout) begin
                  // Bits never received count as errors
                  w_state_nxt  = DONE;
                  w_pub        = 1'b1;
                  w_set_stall  = 1'b1;
                  w_n_bits_nxt = w_bit_cnt;
                  w_n_er_nxt   = w_err_cnt + (CW'(WINDOW) - w_bit_cnt);
               end
            end
            DONE: begin
               w_state_nxt = bus.cont ? SYNC : IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // State, lock-run and stall timers, result and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_run     <= '0;
         r_idle    <= '0;
         r_n_er    <= '0;
         r_n_bits  <= '0;
         r_res_val <= 1'b0;
         r_stall   <= 1'b0;
         r_los     <= 1'b0;
         r_busy    <= 1'b0;
         r_locked  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_busy    <= (w_state_nxt != IDLE);
         r_locked  <= (w_state_nxt == MEAS);
         r_res_val <= w_pub;
         if (w_pub) begin
            r_n_er   <= w_n_er_nxt;
            r_n_bits <= w_n_bits_nxt;
         end
         if (w_clr_flags)      r_stall <= 1'b0;
         else if (w_set_stall) r_stall <= 1'b1;
         if (w_clr_flags)      r_los <= 1'b0;
         else if (w_set_los)   r_los <= 1'b1;
         // Run of error-free bits, only while hunting for lock
         if (w_state_nxt != SYNC)             r_run <= '0;
         else if (r_state == SYNC && bus.val) r_run <= bus.err ? '0 : r_run + RW'(1);
         // Cycles without val while searching or measuring
         if (bus.val || w_state_nxt == IDLE || w_state_nxt == DONE) r_idle <= '0;
         else if (r_state == SYNC || r_state == MEAS)               r_idle <= r_idle + IW'(1);
      end
   end

   assign bus.busy    = r_busy;
   assign bus.locked  = r_locked;
   assign bus.n_er    = r_n_er;
   assign bus.n_bits  = r_n_bits;
   assign bus.res_val = r_res_val;
   assign bus.stall   = r_stall;
   assign bus.los     = r_los;
endmodule
